// File: rtl/usb_tx.sv
// usb_tx: USB full-speed packet transmitter (SYNC, PID, optional payload, CRC16, EOP) with
// bit stuffing and NRZI line coding. Define USB_TX_DATA1_EN to accept tx_packet=5 (DATA1).
module usb_tx #(
   parameter int CLKS_PER_BIT = 8,
   parameter int MAX_BYTES    = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [2:0]                     tx_packet,
   input  logic [$clog2(MAX_BYTES+1)-1:0] buffer_occupancy,
   input  logic [7:0]                     tx_packet_data,
   output logic                           get_tx_packet_data,
   output logic                           tx_transfer_active,
   output logic                           tx_error,
   output logic                           d_plus,
   output logic                           d_minus
);

   localparam int OCC_W = $clog2(MAX_BYTES + 1);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_PID,
      S_DATA,
      S_CRC,
      S_EOP_SE0,
      S_EOP_J
   } state_t;

   // Field position: state/bit_idx name the field bit most recently put on the line
   // (a stuff bit leaves them pointing at the bit it follows).
   state_t           state;
   logic [3:0]       bit_idx;
   logic [7:0]       cur_byte;
   logic [7:0]       pid_byte;
   logic [7:0]       next_byte;
   logic [15:0]      crc;
   logic [OCC_W-1:0] bytes_left;
   logic             is_data;
   logic             fetched;
   logic             capture_pending;
   logic             line_j;
   logic [2:0]       ones_cnt;
   logic [CNT_W-1:0] clk_cnt;

   logic             req_legal;
   logic             req_data;
   logic [7:0]       req_pid;

   state_t           nxt_state;
   logic [3:0]       nxt_idx;
   logic [7:0]       nxt_byte;
   logic             nxt_load;
   logic             nxt_bit;
   logic             nxt_line;
   logic             pop;
   logic             stuff_due;
   logic             crc_fb;
   logic [15:0]      crc_upd;

   always_comb begin
      req_legal = 1'b1;
      req_data  = 1'b0;
      req_pid   = 8'h00;
      case (tx_packet)
         3'd1: begin req_pid = 8'hC3; req_data = 1'b1; end
         3'd2: req_pid = 8'hD2;
         3'd3: req_pid = 8'h5A;
         3'd4: req_pid = 8'h1E;
`ifdef USB_TX_DATA1_EN
         3'd5: begin req_pid = 8'h4B; req_data = 1'b1; end
`endif
         default: req_legal = 1'b0;
      endcase
   end

   // Next field bit after the current one, ignoring stuffing.
   always_comb begin
      nxt_state = state;
      nxt_idx   = bit_idx + 4'd1;
      nxt_byte  = cur_byte;
      nxt_load  = 1'b0;
      case (state)
         S_SYNC: begin
            if (bit_idx == 4'd7) begin
               nxt_state = S_PID;
               nxt_idx   = 4'd0;
               nxt_byte  = pid_byte;
            end
         end
         S_PID, S_DATA: begin
            if (bit_idx == 4'd7) begin
               nxt_idx = 4'd0;
               if (!is_data) begin
                  nxt_state = S_EOP_SE0;
               end else if (fetched) begin
                  nxt_state = S_DATA;
                  nxt_byte  = next_byte;
                  nxt_load  = 1'b1;
               end else begin
                  nxt_state = S_CRC;
               end
            end
         end
         S_CRC: begin
            if (bit_idx == 4'd15) begin
               nxt_state = S_EOP_SE0;
               nxt_idx   = 4'd0;
            end
         end
         S_EOP_SE0: begin
            if (bit_idx == 4'd1) begin
               nxt_state = S_EOP_J;
               nxt_idx   = 4'd0;
            end
         end
         S_EOP_J: begin
            nxt_state = S_IDLE;
            nxt_idx   = 4'd0;
         end
         default: ;
      endcase

      nxt_bit  = (nxt_state == S_CRC) ? ~crc[4'd15 - nxt_idx] : nxt_byte[nxt_idx[2:0]];
      nxt_line = nxt_bit ? line_j : ~line_j;
      pop      = (nxt_state == S_PID || nxt_state == S_DATA) && (nxt_idx == 4'd7) &&
                 is_data && (bytes_left != '0);
      stuff_due = (state == S_SYNC || state == S_PID || state == S_DATA || state == S_CRC) &&
                  (ones_cnt == 3'd6);
      crc_fb   = nxt_bit ^ crc[15];
      crc_upd  = {crc[14:0], 1'b0} ^ (crc_fb ? 16'h8005 : 16'h0000);
   end

   // Buffer handshake: get_tx_packet_data is a one-cycle pop; the buffer presents the
   // popped byte on tx_packet_data in the following cycle, where it is captured.
   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= S_IDLE;
         bit_idx            <= 4'd0;
         cur_byte           <= 8'h00;
         pid_byte           <= 8'h00;
         next_byte          <= 8'h00;
         crc                <= 16'hFFFF;
         bytes_left         <= '0;
         is_data            <= 1'b0;
         fetched            <= 1'b0;
         capture_pending    <= 1'b0;
         line_j             <= 1'b1;
         ones_cnt           <= 3'd0;
         clk_cnt            <= '0;
         get_tx_packet_data <= 1'b0;
         tx_transfer_active <= 1'b0;
         tx_error           <= 1'b0;
         d_plus             <= 1'b1;
         d_minus            <= 1'b0;
      end else begin
         get_tx_packet_data <= 1'b0;
         tx_error           <= 1'b0;
         if (state == S_IDLE) begin
            clk_cnt <= '0;
            if (tx_packet != 3'd0) begin
               if (req_legal) begin
                  state              <= S_SYNC;
                  bit_idx            <= 4'd0;
                  cur_byte           <= 8'h80;
                  pid_byte           <= req_pid;
                  is_data            <= req_data;
                  bytes_left         <= buffer_occupancy;
                  crc                <= 16'hFFFF;
                  fetched            <= 1'b0;
                  capture_pending    <= 1'b0;
                  ones_cnt           <= 3'd0;
                  // SYNC bit 0 is a 0, so the line leaves idle J for K immediately.
                  line_j             <= 1'b0;
                  d_plus             <= 1'b0;
                  d_minus            <= 1'b1;
                  tx_transfer_active <= 1'b1;
               end else begin
                  tx_error <= 1'b1;
               end
            end
         end else begin
            if (capture_pending && clk_cnt == CNT_ONE) begin
               next_byte       <= tx_packet_data;
               capture_pending <= 1'b0;
            end
            if (clk_cnt != CNT_LAST) begin
               clk_cnt <= clk_cnt + CNT_ONE;
            end else begin
               clk_cnt <= '0;
               if (stuff_due) begin
                  line_j   <= ~line_j;
                  d_plus   <= ~line_j;
                  d_minus  <= line_j;
                  ones_cnt <= 3'd0;
               end else begin
                  state    <= nxt_state;
                  bit_idx  <= nxt_idx;
                  cur_byte <= nxt_byte;
                  if (nxt_load) fetched <= 1'b0;
                  if (pop) begin
                     get_tx_packet_data <= 1'b1;
                     bytes_left         <= bytes_left - OCC_ONE;
                     fetched            <= 1'b1;
                     capture_pending    <= 1'b1;
                  end
                  case (nxt_state)
                     S_SYNC, S_PID, S_DATA, S_CRC: begin
                        line_j   <= nxt_line;
                        d_plus   <= nxt_line;
                        d_minus  <= ~nxt_line;
                        ones_cnt <= nxt_bit ? ones_cnt + 3'd1 : 3'd0;
                        if (nxt_state == S_DATA) crc <= crc_upd;
                     end
                     S_EOP_SE0: begin
                        d_plus  <= 1'b0;
                        d_minus <= 1'b0;
                     end
                     S_EOP_J: begin
                        line_j  <= 1'b1;
                        d_plus  <= 1'b1;
                        d_minus <= 1'b0;
                     end
                     default: begin
                        tx_transfer_active <= 1'b0;
                        line_j             <= 1'b1;
                        d_plus             <= 1'b1;
                        d_minus            <= 1'b0;
                     end
                  endcase
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_usb_tx.sv
// tb_usb_tx: self-checking bench for usb_tx -- table vectors, hand-written corner sequences and
// random packets compared against a bit-level line model built from the protocol rules.
`timescale 1ns/1ps
module tb_usb_tx;
   localparam int C = 8;
   localparam logic [1:0] J   = 2'b10;
   localparam logic [1:0] K   = 2'b01;
   localparam logic [1:0] SE0 = 2'b00;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] tx_packet = 3'd0;
   logic [6:0] buffer_occupancy = 7'd0;
   logic [7:0] tx_packet_data = 8'h00;
   logic       get_tx_packet_data;
   logic       tx_transfer_active;
   logic       tx_error;
   logic       d_plus;
   logic       d_minus;

   int checks = 0;
   int errors = 0;

   logic [1:0] exp_q[$];
   int         exp_pop_q[$];
   logic [7:0] pay_q[$];
   logic [1:0] obs_q[$];
   int         obs_pop[$];

   typedef struct {
      logic [2:0] code;
      int         len;
      int         exp_active;
      int         exp_err;
   } vec_t;
   vec_t vecs[7];

   logic [1:0] ack_seq[19];

   usb_tx #(.CLKS_PER_BIT(C), .MAX_BYTES(64)) dut (
      .clk                (clk),
      .rst                (rst),
      .tx_packet          (tx_packet),
      .buffer_occupancy   (buffer_occupancy),
      .tx_packet_data     (tx_packet_data),
      .get_tx_packet_data (get_tx_packet_data),
      .tx_transfer_active (tx_transfer_active),
      .tx_error           (tx_error),
      .d_plus             (d_plus),
      .d_minus            (d_minus)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Expected line symbol per bit time plus expected pop cycles, from the protocol rules.
   task automatic build_model(input logic [2:0] code);
      logic       raw[$];
      logic       pop_tag[$];
      logic [7:0] pid;
      logic [15:0] crc;
      logic       data_pkt;
      logic       lvl_j;
      int         run;
      int         n;
      exp_q.delete();
      exp_pop_q.delete();
      case (code)
         3'd1:    pid = 8'hC3;
         3'd2:    pid = 8'hD2;
         3'd3:    pid = 8'h5A;
         3'd4:    pid = 8'h1E;
         default: pid = 8'h4B;
      endcase
      data_pkt = (code == 3'd1) || (code == 3'd5);
      n = data_pkt ? pay_q.size() : 0;
      for (int i = 0; i < 8; i++) begin
         raw.push_back(i == 7);
         pop_tag.push_back(1'b0);
      end
      for (int i = 0; i < 8; i++) begin
         raw.push_back(pid[i]);
         pop_tag.push_back(i == 7 && n > 0);
      end
      if (data_pkt) begin
         crc = 16'hFFFF;
         for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 8; i++) begin
               raw.push_back(pay_q[k][i]);
               pop_tag.push_back(i == 7 && k + 1 < n);
            end
            crc = crc ^ {8'h00, pay_q[k]};
            for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
         end
         crc = ~crc;
         for (int i = 0; i < 16; i++) begin
            raw.push_back(crc[i]);
            pop_tag.push_back(1'b0);
         end
      end
      run = 0;
      lvl_j = 1'b1;
      for (int i = 0; i < raw.size(); i++) begin
         if (pop_tag[i]) exp_pop_q.push_back(exp_q.size() * C);
         if (!raw[i]) lvl_j = !lvl_j;
         exp_q.push_back(lvl_j ? J : K);
         if (raw[i]) begin
            run++;
            if (run == 6) begin
               lvl_j = !lvl_j;
               exp_q.push_back(lvl_j ? J : K);
               run = 0;
            end
         end else begin
            run = 0;
         end
      end
      exp_q.push_back(SE0);
      exp_q.push_back(SE0);
      exp_q.push_back(J);
   endtask

   task automatic run_packet(input string name, input logic [2:0] code, input int abort_at);
      int         nbits, limit, wave_bad, act_bad, first_bad, err_seen, pidx, npop;
      logic [1:0] line, want, first_got, first_want;
      logic       want_act;
      build_model(code);
      nbits = exp_q.size();
      limit = nbits * C + 8;
      obs_q.delete();
      obs_pop.delete();
      wave_bad = 0; act_bad = 0; first_bad = -1; err_seen = 0; pidx = 0;
      first_got = 2'b00; first_want = 2'b00;
      @(negedge clk);
      tx_packet = code;
      buffer_occupancy = 7'(pay_q.size());
      @(negedge clk);
      tx_packet = 3'd0;
      buffer_occupancy = 7'($urandom_range(0, 64));
      for (int c = 0; c < limit; c++) begin
         if (abort_at > 0 && c == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            check({name, " rst d_plus"}, 32'(d_plus), 32'd1);
            check({name, " rst d_minus"}, 32'(d_minus), 32'd0);
            check({name, " rst get"}, 32'(get_tx_packet_data), 32'd0);
            check({name, " rst active"}, 32'(tx_transfer_active), 32'd0);
            check({name, " rst error"}, 32'(tx_error), 32'd0);
            rst = 1'b0;
            return;
         end
         line = {d_plus, d_minus};
         want_act = (c < nbits * C);
         want = want_act ? exp_q[c / C] : J;
         if (line !== want) begin
            if (wave_bad == 0) begin
               first_bad = c; first_got = line; first_want = want;
            end
            wave_bad++;
         end
         if (tx_transfer_active !== want_act) act_bad++;
         if (tx_error) err_seen++;
         if (c % C == C / 2) obs_q.push_back(line);
         if (get_tx_packet_data) begin
            obs_pop.push_back(c);
            tx_packet_data = (pidx < pay_q.size()) ? pay_q[pidx] : 8'h00;
            pidx++;
         end
         if (c == 40) tx_packet = 3'd7;
         if (c == 41) tx_packet = 3'd0;
         @(negedge clk);
      end
      checks++;
      if (wave_bad != 0) begin
         errors++;
         $display("FAIL %s line: %0d bad cycles, first at cycle %0d got %b expected %b",
                  name, wave_bad, first_bad, first_got, first_want);
      end
      check({name, " active cycles wrong"}, 32'(act_bad), 32'd0);
      check({name, " tx_error pulses"}, 32'(err_seen), 32'd0);
      check({name, " pop count"}, 32'(obs_pop.size()), 32'(exp_pop_q.size()));
      npop = (obs_pop.size() < exp_pop_q.size()) ? obs_pop.size() : exp_pop_q.size();
      for (int i = 0; i < npop; i++) check({name, " pop cycle"}, 32'(obs_pop[i]), 32'(exp_pop_q[i]));
   endtask

   task automatic apply_vec(input int i);
      int act_cnt, err_cnt, moved, pops;
      act_cnt = 0; err_cnt = 0; moved = 0; pops = 0;
      pay_q.delete();
      @(negedge clk);
      tx_packet = vecs[i].code;
      buffer_occupancy = 7'(vecs[i].len);
      @(negedge clk);
      tx_packet = 3'd0;
      for (int c = 0; c < 320; c++) begin
         if (tx_transfer_active) act_cnt++;
         if (tx_error) err_cnt++;
         if ({d_plus, d_minus} !== J) moved++;
         if (get_tx_packet_data) pops++;
         @(negedge clk);
      end
      check($sformatf("vec%0d code%0d active clks", i, vecs[i].code), 32'(act_cnt), 32'(vecs[i].exp_active));
      check($sformatf("vec%0d code%0d error pulses", i, vecs[i].code), 32'(err_cnt), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d code%0d pops", i, vecs[i].code), 32'(pops), 32'd0);
      if (vecs[i].exp_active == 0)
         check($sformatf("vec%0d code%0d idle line", i, vecs[i].code), 32'(moved), 32'd0);
   endtask

   initial begin
      vecs[0] = '{code: 3'd2, len: 0, exp_active: 152, exp_err: 0};
      vecs[1] = '{code: 3'd3, len: 0, exp_active: 152, exp_err: 0};
      vecs[2] = '{code: 3'd4, len: 0, exp_active: 152, exp_err: 0};
      vecs[3] = '{code: 3'd1, len: 0, exp_active: 280, exp_err: 0};
      vecs[4] = '{code: 3'd7, len: 0, exp_active: 0,   exp_err: 1};
      vecs[5] = '{code: 3'd6, len: 3, exp_active: 0,   exp_err: 1};
`ifdef USB_TX_DATA1_EN
      vecs[6] = '{code: 3'd5, len: 0, exp_active: 280, exp_err: 0};
`else
      vecs[6] = '{code: 3'd5, len: 2, exp_active: 0,   exp_err: 1};
`endif
      ack_seq = '{K, J, K, J, K, J, K, K, J, J, K, J, J, K, K, K, SE0, SE0, J};

      // clock/reset
      repeat (3) @(negedge clk);
      check("reset d_plus", 32'(d_plus), 32'd1);
      check("reset d_minus", 32'(d_minus), 32'd0);
      check("reset get", 32'(get_tx_packet_data), 32'd0);
      check("reset active", 32'(tx_transfer_active), 32'd0);
      check("reset error", 32'(tx_error), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) apply_vec(i);

      // ACK line sequence from idle
      pay_q.delete();
      run_packet("ack", 3'd2, 0);
      for (int b = 0; b < 19; b++) check($sformatf("ack bit %0d", b), 32'(obs_q[b]), 32'(ack_seq[b]));

      // zero-length DATA0
      pay_q.delete();
      run_packet("data0 empty", 3'd1, 0);

      // single 0xFF byte: pop in final PID bit, stuff after data bit 3
      pay_q.delete();
      pay_q.push_back(8'hFF);
      run_packet("data0 ff", 3'd1, 0);
      check("ff pop count", 32'(obs_pop.size()), 32'd1);
      if (obs_pop.size() > 0) check("ff pop cycle", 32'(obs_pop[0]), 32'd120);
      check("ff data bits hold", 32'(obs_q[19] == obs_q[15] && obs_q[17] == obs_q[15]), 32'd1);
      check("ff stuff toggles", 32'(obs_q[20] != obs_q[19]), 32'd1);

      // reset mid-DATA, then a NAK
      pay_q.delete();
      pay_q.push_back(8'h11);
      pay_q.push_back(8'h22);
      pay_q.push_back(8'h33);
      run_packet("abort", 3'd1, 160);
      repeat (2) @(negedge clk);
      pay_q.delete();
      run_packet("nak after reset", 3'd3, 0);

`ifdef USB_TX_DATA1_EN
      pay_q.delete();
      pay_q.push_back(8'($urandom_range(0, 255)));
      pay_q.push_back(8'($urandom_range(0, 255)));
      run_packet("data1", 3'd5, 0);
      begin
         logic [7:0] pid_seen;
         for (int i = 0; i < 8; i++) pid_seen[i] = (obs_q[8 + i] == obs_q[7 + i]);
         check("data1 pid bits", 32'(pid_seen), 32'h4B);
      end
`endif

      // random packets
      for (int n = 0; n < 8; n++) begin
         int code_i;
         int len;
`ifdef USB_TX_DATA1_EN
         code_i = $urandom_range(1, 5);
`else
         code_i = $urandom_range(1, 4);
`endif
         len = $urandom_range(0, 6);
         pay_q.delete();
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 3) == 0) pay_q.push_back(8'hFF);
            else pay_q.push_back(8'($urandom_range(0, 255)));
         end
         run_packet($sformatf("rand%0d code%0d len%0d", n, code_i, len), 3'(code_i), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
